// File: rtl/operand_skew_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_skew_sequencer_if
//  Description : Control/status bundle between the matrix-level controller
//                (master) and one operand skew sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_skew_sequencer_if #(
  parameter int NUM_LANES       = 32,
  parameter int MAX_K_SIZE_LOG2 = 9,
  parameter int SRAM_AWIDTH     = 10
);

  // Controller -> sequencer
  logic                       start;
  logic                       stall;
  logic [MAX_K_SIZE_LOG2-1:0] k_size;
  logic [SRAM_AWIDTH-1:0]     base_addr;

  // Sequencer -> SRAM / skew FIFOs / PE array / controller
  logic [SRAM_AWIDTH-1:0]     sram_addr;
  logic                       sram_ren;
  logic [NUM_LANES-1:0]       pushes;
  logic [NUM_LANES-1:0]       popes;
  logic                       is_computing;
  logic                       is_flushing;
  logic                       busy;
  logic                       done;

  modport master (
    output start, stall, k_size, base_addr,
    input  sram_addr, sram_ren, pushes, popes,
    input  is_computing, is_flushing, busy, done
  );

  modport slave (
    input  start, stall, k_size, base_addr,
    output sram_addr, sram_ren, pushes, popes,
    output is_computing, is_flushing, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/operand_skew_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : operand_skew_sequencer
//  Description : Sequences one K-deep operand pass: SRAM row reads, skew-FIFO
//                pushes on every lane, diagonal pops (lane i lags i cycles),
//                then a fixed-length PE drain phase and a one-cycle DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_skew_sequencer #(
  parameter int NUM_LANES       = 32,
  parameter int NUM_LANES_LOG2  = 5,
  parameter int MAX_K_SIZE_LOG2 = 9,
  parameter int SRAM_AWIDTH     = 10,
  parameter int FLUSH_CYCLES    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  operand_skew_sequencer_if.slave bus
);

  // Run counter is one bit wider than K so K + NUM_LANES - 1 never wraps.
  localparam int c_cw = MAX_K_SIZE_LOG2 + 1;
  localparam int c_fw = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // Highest lane index, i.e. the extra diagonal cycles after the last push.
  localparam logic [NUM_LANES_LOG2-1:0] c_lane_max   = NUM_LANES_LOG2'(NUM_LANES - 1);
  localparam logic [c_fw-1:0]           c_flush_last = c_fw'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [c_cw-1:0]            r_c, w_c_nxt;
  logic [c_fw-1:0]            r_f, w_f_nxt;
  logic [MAX_K_SIZE_LOG2-1:0] r_k, w_k_nxt;
  logic [SRAM_AWIDTH-1:0]     r_base, w_base_nxt;

  logic [c_cw-1:0]            w_k_ext;
  logic [c_cw-1:0]            w_run_last;
  logic                       w_rd_win;
  logic                       w_push_win;
  logic                       w_comp_win;
  logic [NUM_LANES-1:0]       w_pop_win;

  assign w_k_ext    = {1'b0, r_k};
  assign w_run_last = w_k_ext + c_cw'(c_lane_max);

  // Read window c = 0..K-1; data lands one cycle later, hence pushes at 1..K.
  assign w_rd_win   = (r_c < w_k_ext);
  assign w_push_win = (r_c >= c_cw'(1)) && (r_c <= w_k_ext);
  assign w_comp_win = (r_c >= c_cw'(1)) && (r_c <= w_run_last);

  // Lane i pops K entries starting i cycles after lane 0; lane 0 pops in its
  // push cycle and so behaves as a FIFO bypass.
  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign w_pop_win[i] = (r_c >= c_cw'(i + 1)) && (r_c <= (w_k_ext + c_cw'(i)));
    end
  endgenerate

  // State, pass counters and latched pass parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_f     <= '0;
      r_k     <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_f     <= w_f_nxt;
      r_k     <= w_k_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // Next-state/counter logic and output decode; STALL freezes progress and
  // masks every enable and the DONE pulse, while the phase flags hold.
  always_comb begin
    w_state_nxt      = r_state;
    w_c_nxt          = r_c;
    w_f_nxt          = r_f;
    w_k_nxt          = r_k;
    w_base_nxt       = r_base;
    bus.sram_addr    = '0;
    bus.sram_ren     = 1'b0;
    bus.pushes       = '0;
    bus.popes        = '0;
    bus.is_computing = 1'b0;
    bus.is_flushing  = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stall) begin
          w_k_nxt     = bus.k_size;
          w_base_nxt  = bus.base_addr;
          w_c_nxt     = '0;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        bus.busy         = 1'b1;
        bus.is_computing = w_comp_win;
        if (w_rd_win) begin
          bus.sram_addr = r_base + SRAM_AWIDTH'(r_c);
          bus.sram_ren  = !bus.stall;
        end
        if (!bus.stall) begin
          if (w_push_win) begin
            bus.pushes = '1;
          end
          bus.popes = w_pop_win;
          // An empty pass has nothing to drain: one RUN cycle, then FIN.
          if (r_k == '0) begin
            w_state_nxt = S_FIN;
          end else if (r_c == w_run_last) begin
            w_f_nxt     = '0;
            w_state_nxt = S_FLUSH;
          end else begin
            w_c_nxt = r_c + c_cw'(1);
          end
        end
      end

      S_FLUSH: begin
        bus.busy        = 1'b1;
        bus.is_flushing = 1'b1;
        if (!bus.stall) begin
          if (r_f == c_flush_last) begin
            w_state_nxt = S_FIN;
          end else begin
            w_f_nxt = r_f + c_fw'(1);
          end
        end
      end

      S_FIN: begin
        bus.busy = 1'b1;
        // Holding FIN under stall keeps the DONE pulse from being lost.
        if (!bus.stall) begin
          bus.done    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
